// File: rtl/tipi_nibble_port.sv
// Pi-side nibble transport for the TIPI latches: synchronizes the Pi strobe,
// framing reset and nibble bus, then runs the CMD/HI/LO byte transfer FSM.
module tipi_nibble_port #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       r_reset,
  input  logic       r_clk,
  input  logic       r_nibrst,
  input  logic [3:0] r_nib_in,
  output logic [3:0] r_nib_out,
  output logic       r_nib_oe,
  input  logic [7:0] td,
  input  logic [7:0] tc,
  output logic [7:0] rd_q,
  output logic [7:0] rc_q,
  output logic       rd_wr,
  output logic       rc_wr,
  output logic       busy,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    S_CMD,
    S_HI,
    S_LO
  } state_t;

  logic [SYNC_STAGES-1:0]      clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0]      rst_sync_q, rst_sync_d;
  logic [SYNC_STAGES-1:0][3:0] nib_sync_q, nib_sync_d;
  logic                        clk_prev_q, clk_prev_d;

  state_t     state_q, state_d;
  logic       wr_q, wr_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] snap_q, snap_d;
  logic [3:0] hi_q, hi_d;
  logic [7:0] rd_d, rc_d;
  logic [7:0] rd_r_q, rc_r_q;
  logic       rd_wr_q, rd_wr_d;
  logic       rc_wr_q, rc_wr_d;
  logic       oe_q, oe_d;
  logic [3:0] out_q, out_d;
  logic       err_q, err_d;

  logic       clk_s;
  logic       nrst_s;
  logic [3:0] nib_s;
  logic       strobe;
  logic [7:0] sel_val;

  // Nibble bus goes through the same depth as the strobe so it is
  // delay-matched when the rising edge is seen.
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], r_clk};
    rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], r_nibrst};
    nib_sync_d = {nib_sync_q[SYNC_STAGES-2:0], r_nib_in};
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign nrst_s = rst_sync_q[SYNC_STAGES-1];
  assign nib_s  = nib_sync_q[SYNC_STAGES-1];
  assign strobe = clk_s & ~clk_prev_q;
  assign clk_prev_d = clk_s;

  always_comb begin
    sel_val = td;
    unique case (nib_s[1:0])
      2'b00: sel_val = td;
      2'b01: sel_val = tc;
      2'b10: sel_val = rd_r_q;
      2'b11: sel_val = rc_r_q;
      default: sel_val = td;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    snap_d  = snap_q;
    hi_d    = hi_q;
    rd_d    = rd_r_q;
    rc_d    = rc_r_q;
    rd_wr_d = 1'b0;
    rc_wr_d = 1'b0;
    oe_d    = oe_q;
    out_d   = out_q;
    err_d   = err_q;
    if (nrst_s) begin
      state_d = S_CMD;
      oe_d    = 1'b0;
      out_d   = 4'h0;
    end else if (strobe) begin
      unique case (state_q)
        S_CMD: begin
          if (nib_s[2] || (nib_s[3] && !nib_s[1])) begin
            err_d = 1'b1;
          end else begin
            wr_d    = nib_s[3];
            sel_d   = nib_s[1:0];
            state_d = S_HI;
            if (!nib_s[3]) begin
              snap_d = sel_val;
              oe_d   = 1'b1;
              out_d  = sel_val[7:4];
            end
          end
        end
        S_HI: begin
          if (wr_q) hi_d = nib_s;
          else out_d = snap_q[3:0];
          state_d = S_LO;
        end
        S_LO: begin
          if (wr_q) begin
            if (sel_q[0]) begin
              rc_d    = {hi_q, nib_s};
              rc_wr_d = 1'b1;
            end else begin
              rd_d    = {hi_q, nib_s};
              rd_wr_d = 1'b1;
            end
          end else begin
            oe_d  = 1'b0;
            out_d = 4'h0;
          end
          state_d = S_CMD;
        end
        default: state_d = S_CMD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_reset) begin
      clk_sync_q <= '0;
      rst_sync_q <= '0;
      nib_sync_q <= '0;
      clk_prev_q <= 1'b0;
      state_q    <= S_CMD;
      wr_q       <= 1'b0;
      sel_q      <= 2'b00;
      snap_q     <= 8'h00;
      hi_q       <= 4'h0;
      rd_r_q     <= 8'h00;
      rc_r_q     <= 8'h00;
      rd_wr_q    <= 1'b0;
      rc_wr_q    <= 1'b0;
      oe_q       <= 1'b0;
      out_q      <= 4'h0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      rst_sync_q <= rst_sync_d;
      nib_sync_q <= nib_sync_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      wr_q       <= wr_d;
      sel_q      <= sel_d;
      snap_q     <= snap_d;
      hi_q       <= hi_d;
      rd_r_q     <= rd_d;
      rc_r_q     <= rc_d;
      rd_wr_q    <= rd_wr_d;
      rc_wr_q    <= rc_wr_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

  assign r_nib_out = oe_q ? out_q : 4'h0;
  assign r_nib_oe  = oe_q;
  assign rd_q      = rd_r_q;
  assign rc_q      = rc_r_q;
  assign rd_wr     = rd_wr_q;
  assign rc_wr     = rc_wr_q;
  assign busy      = (state_q != S_CMD);
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_tipi_nibble_port.sv
// Directed bench for tipi_nibble_port: read, write, framing reset,
// illegal commands and snapshot stability.
module tb_tipi_nibble_port;

  logic       clk;
  logic       r_reset;
  logic       r_clk;
  logic       r_nibrst;
  logic [3:0] r_nib_in;
  logic [3:0] r_nib_out;
  logic       r_nib_oe;
  logic [7:0] td;
  logic [7:0] tc;
  logic [7:0] rd_q;
  logic [7:0] rc_q;
  logic       rd_wr;
  logic       rc_wr;
  logic       busy;
  logic       cmd_err;

  int checks;
  int failures;
  int rd_wr_cnt;
  int rc_wr_cnt;
  int rd0;
  int rc0;

  tipi_nibble_port #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .r_reset   (r_reset),
    .r_clk     (r_clk),
    .r_nibrst  (r_nibrst),
    .r_nib_in  (r_nib_in),
    .r_nib_out (r_nib_out),
    .r_nib_oe  (r_nib_oe),
    .td        (td),
    .tc        (tc),
    .rd_q      (rd_q),
    .rc_q      (rc_q),
    .rd_wr     (rd_wr),
    .rc_wr     (rc_wr),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_wr) rd_wr_cnt <= rd_wr_cnt + 1;
    if (rc_wr) rc_wr_cnt <= rc_wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] nib);
    r_nib_in = nib;
    r_clk    = 1'b1;
    cyc(4);
    r_clk    = 1'b0;
    cyc(4);
  endtask

  task automatic do_reset();
    r_reset = 1'b1;
    cyc(3);
    r_reset = 1'b0;
    cyc(2);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_oe"}, {31'd0, r_nib_oe}, 0);
    chk({tag, "_out"}, {28'd0, r_nib_out}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rd_wr_cnt = 0;
    rc_wr_cnt = 0;
    r_reset   = 1'b1;
    r_clk     = 1'b0;
    r_nibrst  = 1'b0;
    r_nib_in  = 4'h0;
    td        = 8'hAA;
    tc        = 8'h3C;
    cyc(3);
    r_reset = 1'b0;
    cyc(2);

    chk_idle("rst");
    chk("rst_rd", {24'd0, rd_q}, 0);
    chk("rst_rc", {24'd0, rc_q}, 0);
    chk("rst_err", {31'd0, cmd_err}, 0);

    // read TD
    strobe(4'h0);
    chk("rtd_oe", {31'd0, r_nib_oe}, 1);
    chk("rtd_hi", {28'd0, r_nib_out}, 32'hA);
    chk("rtd_busy", {31'd0, busy}, 1);
    strobe(4'h7);
    chk("rtd_lo", {28'd0, r_nib_out}, 32'hA);
    strobe(4'h9);
    chk_idle("rtd_end");

    // write RD
    rd0 = rd_wr_cnt;
    rc0 = rc_wr_cnt;
    strobe(4'hA);
    chk("wrd_oe", {31'd0, r_nib_oe}, 0);
    chk("wrd_busy", {31'd0, busy}, 1);
    strobe(4'h5);
    chk("wrd_mid", {24'd0, rd_q}, 0);
    strobe(4'h5);
    chk("wrd_val", {24'd0, rd_q}, 32'h55);
    chk("wrd_pulse", rd_wr_cnt - rd0, 1);
    chk("wrd_rc", {24'd0, rc_q}, 0);
    chk("wrd_rcp", rc_wr_cnt - rc0, 0);

    // write RC then read it back
    rc0 = rc_wr_cnt;
    strobe(4'hB);
    strobe(4'hF);
    strobe(4'hF);
    chk("wrc_val", {24'd0, rc_q}, 32'hFF);
    chk("wrc_pulse", rc_wr_cnt - rc0, 1);
    strobe(4'h3);
    chk("rrc_hi", {28'd0, r_nib_out}, 32'hF);
    strobe(4'h0);
    chk("rrc_lo", {28'd0, r_nib_out}, 32'hF);
    strobe(4'h0);
    chk_idle("rrc_end");

    // framing reset aborts a partial write
    do_reset();
    rd0 = rd_wr_cnt;
    strobe(4'hA);
    strobe(4'h1);
    r_nibrst = 1'b1;
    cyc(5);
    chk("nrst_busy", {31'd0, busy}, 0);
    r_nibrst = 1'b0;
    cyc(4);
    strobe(4'h1);
    chk("nrst_rd", {24'd0, rd_q}, 0);
    chk("nrst_pulse", rd_wr_cnt - rd0, 0);
    chk("rtc_hi", {28'd0, r_nib_out}, 32'h3);
    strobe(4'h0);
    chk("rtc_lo", {28'd0, r_nib_out}, 32'hC);
    // framing reset during a read drops oe; strobes ignored while high
    r_nibrst = 1'b1;
    cyc(5);
    chk("nrst_oe", {31'd0, r_nib_oe}, 0);
    strobe(4'h0);
    chk("nrst_ign", {31'd0, busy}, 0);
    r_nibrst = 1'b0;
    cyc(4);

    // illegal commands
    strobe(4'h8);
    chk("ill_err", {31'd0, cmd_err}, 1);
    chk_idle("ill");
    strobe(4'h4);
    chk("ill2_err", {31'd0, cmd_err}, 1);
    chk("ill2_busy", {31'd0, busy}, 0);
    strobe(4'h1);
    strobe(4'h0);
    strobe(4'h0);
    chk("ill_sticky", {31'd0, cmd_err}, 1);

    // snapshot holds when td changes mid-read
    td = 8'h12;
    strobe(4'h0);
    chk("snap_hi", {28'd0, r_nib_out}, 32'h1);
    td = 8'h34;
    strobe(4'h0);
    chk("snap_lo", {28'd0, r_nib_out}, 32'h2);
    strobe(4'h0);
    chk_idle("snap_end");

    // r_reset mid-write
    strobe(4'hA);
    strobe(4'h6);
    r_reset = 1'b1;
    cyc(2);
    chk_idle("mrst");
    chk("mrst_err", {31'd0, cmd_err}, 0);
    chk("mrst_rd", {24'd0, rd_q}, 0);
    chk("mrst_rc", {24'd0, rc_q}, 0);
    chk("mrst_wr", {30'd0, rd_wr, rc_wr}, 0);
    r_reset = 1'b0;
    cyc(2);
    strobe(4'h6);
    chk("mrst_cmd", {24'd0, rd_q}, 0);
    chk("mrst_st", {31'd0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
